// File: rtl/mul_inner_tc.sv
// Unary temporal multiply cell: forwards the input stream east and counts product bits over a 2^(WIDTH-1) window.
// Optional signed stepping is enabled by defining MUL_INNER_TC_SIGN_EN.
module mul_inner_tc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit_i,
  input  logic             i_sign_i,
  input  logic [WIDTH-2:0] i_randW,
  input  logic             i_w_load,
  input  logic [WIDTH-1:0] i_data_w,
  input  logic             i_start,
  input  logic             i_en,
  output logic             o_bit_i,
  output logic             o_sign_i,
  output logic [WIDTH-2:0] o_randW,
  output logic             o_bit,
  output logic [WIDTH:0]   o_acc,
  output logic             o_valid,
  output logic             o_busy
);

  localparam int MW = WIDTH - 1;
  localparam logic [MW-1:0] CNT_ONE  = MW'(1);
  localparam logic [WIDTH:0] ACC_POS = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [MW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]    acc_q, acc_d;
  logic [WIDTH:0]    acc_out_q, acc_out_d;
  logic [WIDTH-1:0]  w_shadow_q, w_shadow_d;
  logic [WIDTH-1:0]  w_act_q, w_act_d;
  logic              bit_i_q, bit_i_d;
  logic              sign_i_q, sign_i_d;
  logic [MW-1:0]     randw_q, randw_d;
  logic              bit_q, bit_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic              prod_s;
  logic [WIDTH:0]    step_s;
  logic [WIDTH:0]    acc_next_s;
  logic              last_s;

  assign prod_s = i_bit_i & (w_act_q[MW-1:0] > i_randW);

`ifdef MUL_INNER_TC_SIGN_EN
  logic neg_s;
  assign neg_s = i_sign_i ^ w_act_q[WIDTH-1];
  // A negative product bit counts down, so the window result is two's complement.
  assign step_s = prod_s ? (neg_s ? {(WIDTH + 1){1'b1}} : ACC_POS) : '0;
`else
  logic unused_sign_s;
  assign unused_sign_s = w_act_q[WIDTH-1];
  assign step_s = prod_s ? ACC_POS : '0;
`endif

  assign acc_next_s = acc_q + step_s;
  assign last_s     = (cnt_q == {MW{1'b1}});

  // Next-state logic for the stream registers, weights and window FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_out_d  = acc_out_q;
    w_act_d    = w_act_q;
    valid_d    = 1'b0;

    if (i_en) begin
      bit_i_d  = i_bit_i;
      sign_i_d = i_sign_i;
      randw_d  = i_randW;
      bit_d    = prod_s;
    end else begin
      bit_i_d  = bit_i_q;
      sign_i_d = sign_i_q;
      randw_d  = randw_q;
      bit_d    = bit_q;
    end

    if (i_w_load) begin
      w_shadow_d = i_data_w;
    end else begin
      w_shadow_d = w_shadow_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          // A weight loaded together with start bypasses the shadow register.
          w_act_d = i_w_load ? i_data_w : w_shadow_q;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (i_en) begin
          cnt_d = cnt_q + CNT_ONE;
          acc_d = acc_next_s;
          if (last_s) begin
            state_d   = DONE;
            acc_out_d = acc_next_s;
            valid_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // All state and outputs, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_out_q  <= '0;
      w_shadow_q <= '0;
      w_act_q    <= '0;
      bit_i_q    <= 1'b0;
      sign_i_q   <= 1'b0;
      randw_q    <= '0;
      bit_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_out_q  <= acc_out_d;
      w_shadow_q <= w_shadow_d;
      w_act_q    <= w_act_d;
      bit_i_q    <= bit_i_d;
      sign_i_q   <= sign_i_d;
      randw_q    <= randw_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign o_bit_i  = bit_i_q;
  assign o_sign_i = sign_i_q;
  assign o_randW  = randw_q;
  assign o_bit    = bit_q;
  assign o_acc    = acc_out_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_mul_inner_tc.sv
// Directed bench for mul_inner_tc (WIDTH=8); sign expectations follow MUL_INNER_TC_SIGN_EN.
module tb_mul_inner_tc;

  logic       clk;
  logic       rst_n;
  logic       i_bit_i;
  logic       i_sign_i;
  logic [6:0] i_randW;
  logic       i_w_load;
  logic [7:0] i_data_w;
  logic       i_start;
  logic       i_en;
  logic       o_bit_i;
  logic       o_sign_i;
  logic [6:0] o_randW;
  logic       o_bit;
  logic [8:0] o_acc;
  logic       o_valid;
  logic       o_busy;

  int vectors = 0;
  int errors  = 0;
  int cycles;

  mul_inner_tc #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bit_i  (i_bit_i),
    .i_sign_i (i_sign_i),
    .i_randW  (i_randW),
    .i_w_load (i_w_load),
    .i_data_w (i_data_w),
    .i_start  (i_start),
    .i_en     (i_en),
    .o_bit_i  (o_bit_i),
    .o_sign_i (o_sign_i),
    .o_randW  (o_randW),
    .o_bit    (o_bit),
    .o_acc    (o_acc),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic do_load, input logic [7:0] w);
    i_start  = 1'b1;
    i_w_load = do_load;
    i_data_w = w;
    i_en     = 1'b1;
    i_bit_i  = 1'b0;
    i_randW  = 7'd0;
    tick();
    i_start  = 1'b0;
    i_w_load = 1'b0;
    check("busy_after_start", {15'd0, o_busy}, 16'd1);
  endtask

  // kind 1 pulses i_start, kind 2 loads val into the shadow weight, on enabled step 'at'.
  task automatic run_window(input logic toggle, input logic bitv, input logic signv,
                            input int kind, input int at, input logic [7:0] val,
                            input logic [8:0] exp_acc, output int ncyc);
    int k = 0;
    logic en;
    logic [6:0] last_rw = 7'd0;
    logic last_bit = 1'b0;
    ncyc = 0;
    while (k < 128 && ncyc < 400) begin
      en       = toggle ? ncyc[0] : 1'b1;
      i_en     = en;
      i_bit_i  = bitv;
      i_sign_i = signv;
      i_randW  = en ? 7'(k) : 7'($urandom_range(127));
      i_start  = (kind == 1 && k == at && en);
      i_w_load = (kind == 2 && k == at && en);
      i_data_w = val;
      tick();
      ncyc++;
      i_start  = 1'b0;
      i_w_load = 1'b0;
      if (en) begin
        k++;
        last_rw  = 7'(k - 1);
        last_bit = bitv;
        if (k == 5) check("randw_fwd", {9'd0, o_randW}, {9'd0, last_rw});
      end else begin
        check("randw_hold", {9'd0, o_randW}, {9'd0, last_rw});
        check("bit_i_hold", {15'd0, o_bit_i}, {15'd0, last_bit});
      end
      if (k < 128) begin
        if (o_valid !== 1'b0 || o_busy !== 1'b1)
          check("run_flags", {14'd0, o_valid, o_busy}, 16'd1);
      end
    end
    check("done_valid", {15'd0, o_valid}, 16'd1);
    check("done_busy", {15'd0, o_busy}, 16'd0);
    check("done_acc", {7'd0, o_acc}, {7'd0, exp_acc});
  endtask

  task automatic after_done(input logic [8:0] exp_acc);
    i_en = 1'b1;
    tick();
    check("post_valid", {15'd0, o_valid}, 16'd0);
    check("post_acc_hold", {7'd0, o_acc}, {7'd0, exp_acc});
    check("post_busy", {15'd0, o_busy}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_bit_i = 1'b1; i_sign_i = 1'b1; i_randW = 7'h55;
    i_w_load = 1'b0; i_data_w = 8'd0; i_start = 1'b0; i_en = 1'b1;
    tick(); tick();
    check("rst_acc", {7'd0, o_acc}, 16'd0);
    check("rst_flags", {10'd0, o_valid, o_busy, o_bit, o_bit_i, o_sign_i, 1'b0}, 16'd0);
    check("rst_randw", {9'd0, o_randW}, 16'd0);
    rst_n = 1'b1;
    i_sign_i = 1'b0;
    tick();

    // Weight 64, full sweep; a start pulse mid-window must be ignored.
    start(1'b1, 8'd64);
    run_window(1'b0, 1'b1, 1'b0, 1, 10, 8'd0, 9'd64, cycles);
    check("latency_128", 16'(cycles), 16'd128);
    after_done(9'd64);

    start(1'b1, 8'd0);
    run_window(1'b0, 1'b1, 1'b0, 0, 0, 8'd0, 9'd0, cycles);
    after_done(9'd0);

    start(1'b1, 8'd127);
    run_window(1'b0, 1'b1, 1'b0, 0, 0, 8'd0, 9'd127, cycles);
    after_done(9'd127);

    start(1'b1, 8'd64);
    run_window(1'b0, 1'b0, 1'b0, 0, 0, 8'd0, 9'd0, cycles);
    after_done(9'd0);

    // i_en toggling: every other cycle disabled.
    start(1'b1, 8'd64);
    run_window(1'b1, 1'b1, 1'b0, 0, 0, 8'd0, 9'd64, cycles);
    check("toggle_cycles", 16'(cycles), 16'd256);
    after_done(9'd64);

    // Weight sign=1, magnitude 64.
    start(1'b1, 8'hC0);
`ifdef MUL_INNER_TC_SIGN_EN
    run_window(1'b0, 1'b1, 1'b0, 0, 0, 8'd0, 9'h1C0, cycles);
`else
    run_window(1'b0, 1'b1, 1'b0, 0, 0, 8'd0, 9'd64, cycles);
`endif
    check("sign_fwd", {15'd0, o_sign_i}, 16'd0);
    start(1'b1, 8'hC0);
    run_window(1'b0, 1'b1, 1'b1, 0, 0, 8'd0, 9'd64, cycles);
    check("sign_fwd1", {15'd0, o_sign_i}, 16'd1);
    after_done(9'd64);

    // Load 32 mid-window of 64, then restart straight from DONE.
    start(1'b1, 8'd64);
    run_window(1'b0, 1'b1, 1'b0, 2, 60, 8'd32, 9'd64, cycles);
    start(1'b0, 8'd0);
    run_window(1'b0, 1'b1, 1'b0, 0, 0, 8'd0, 9'd32, cycles);
    after_done(9'd32);

    // Asynchronous reset at enabled cycle 50 of RUN.
    start(1'b1, 8'd64);
    for (int k = 0; k < 50; k++) begin
      i_en = 1'b1; i_bit_i = 1'b1; i_randW = 7'(k);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'd0, o_busy}, 16'd0);
    check("mid_rst_acc", {7'd0, o_acc}, 16'd0);
    check("mid_rst_outs", {12'd0, o_valid, o_bit, o_bit_i, 1'b0}, 16'd0);
    check("mid_rst_randw", {9'd0, o_randW}, 16'd0);
    for (int k = 0; k < 90; k++) begin
      tick();
      if (o_valid !== 1'b0) check("rst_no_valid", {15'd0, o_valid}, 16'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 90; k++) begin
      i_en = 1'b1;
      tick();
      if (o_valid !== 1'b0 || o_busy !== 1'b0)
        check("idle_after_rst", {14'd0, o_valid, o_busy}, 16'd0);
    end
    start(1'b1, 8'd64);
    run_window(1'b0, 1'b1, 1'b0, 0, 0, 8'd0, 9'd64, cycles);
    check("rst_latency", 16'(cycles), 16'd128);
    after_done(9'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
